// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS/CTRL bit positions and the transmit FSM state encoding.
package uart_tx_mmio_pkg;

    localparam logic [1:0] UartTxData = 2'd0;
    localparam logic [1:0] UartStatus = 2'd1;
    localparam logic [1:0] UartCtrl   = 2'd2;
    localparam logic [1:0] UartDiv    = 2'd3;

    localparam int StBusy   = 0;
    localparam int StFull   = 1;
    localparam int StEmpty  = 2;
    localparam int StOvf    = 3;
    localparam int StCntLsb = 4;

    localparam int CtrlTxEn  = 0;
    localparam int CtrlIntEn = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push into a full FIFO is
// accepted only when a pop frees a slot on the same edge.
module uart_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count   = wptr - rptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode, CTRL/DIVISOR registers,
// transmit FSM with baud counter and shift register, and the idle interrupt.
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic [3:0]  sel,
    output logic [31:0] data_o,
    output logic        tx,
    output logic        int_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e   state;
    tx_state_e   state_n;
    logic [15:0] divisor;
    logic [15:0] div_eff;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic [7:0]  fifo_rdata;
    logic        tx_en;
    logic        int_en;
    logic        overflow;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CW-1:0] fifo_count;
    logic        wr;
    logic        push;
    logic        pop;
    logic        load;
    logic        bit_end;
    logic        unused_ok;

    assign wr        = ce & we;
    assign push      = wr && (addr[3:2] == UartTxData) && sel[0];
    assign div_eff   = (divisor == 16'd0) ? 16'd1 : divisor;
    assign bit_end   = (baud_cnt == 16'd0);
    assign unused_ok = ^{addr[31:4], addr[1:0], data[31:16], sel[3:2]};

    uart_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (data[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        load    = 1'b0;
        case (state)
            S_IDLE: begin
                if (tx_en && !fifo_empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    load    = 1'b1;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    load = 1'b1;
                    if (bit_idx == 3'd7) state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Divisor is sampled only at bit starts, so mid-frame writes land on the next bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
        end else begin
            if (load)                                baud_cnt <= div_eff - 16'd1;
            else if (state != S_IDLE && !bit_end)    baud_cnt <= baud_cnt - 16'd1;
            if (state == S_START)                    bit_idx  <= 3'd0;
            else if (state == S_DATA && bit_end)     bit_idx  <= bit_idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (pop)                           shift <= fifo_rdata;
        else if (state == S_DATA && bit_end) shift <= {1'b0, shift[7:1]};
    end

    assign tx = (state == S_START) ? 1'b0 :
                (state == S_DATA)  ? shift[0] : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_en    <= 1'b0;
            int_en   <= 1'b0;
            divisor  <= DIV_RESET;
            overflow <= 1'b0;
            int_o    <= 1'b0;
        end else begin
            int_o <= int_en & fifo_empty & (state == S_IDLE);
            if (push && fifo_full && !pop)
                overflow <= 1'b1;
            else if (wr && addr[3:2] == UartStatus && sel[0] && data[StOvf])
                overflow <= 1'b0;
            if (wr && addr[3:2] == UartCtrl && sel[0]) begin
                tx_en  <= data[CtrlTxEn];
                int_en <= data[CtrlIntEn];
            end
            if (wr && addr[3:2] == UartDiv) begin
                if (sel[0]) divisor[7:0]  <= data[7:0];
                if (sel[1]) divisor[15:8] <= data[15:8];
            end
        end
    end

    always_comb begin
        data_o = 32'd0;
        if (ce && !we) begin
            case (addr[3:2])
                UartStatus: begin
                    data_o[StBusy]          = (state != S_IDLE);
                    data_o[StFull]          = fifo_full;
                    data_o[StEmpty]         = fifo_empty;
                    data_o[StOvf]           = overflow;
                    data_o[StCntLsb +: 5]   = 5'(fifo_count);
                end
                UartCtrl: begin
                    data_o[CtrlTxEn]  = tx_en;
                    data_o[CtrlIntEn] = int_en;
                end
                UartDiv:  data_o[15:0] = divisor;
                default:  data_o = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: a frame-level reference model is
// compared against tx, int_o and read data every cycle, plus literal spot checks.
module tb_uart_tx_mmio;

    localparam int DEPTH = 16;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        ce   = 1'b0;
    logic        we   = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] data = 32'd0;
    logic [3:0]  sel  = 4'd0;
    logic [31:0] data_o;
    logic        tx;
    logic        int_o;

    int n_pass  = 0;
    int n_total = 0;

    uart_tx_mmio #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd434)) dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .data(data),
        .sel(sel), .data_o(data_o), .tx(tx), .int_o(int_o)
    );

    always #5 clk = ~clk;

    // Reference model: queue of bytes plus the current frame as 10 line levels.
    logic [7:0]  q[$];
    bit          m_busy  = 0;
    bit          m_ovf   = 0;
    bit          m_txen  = 0;
    bit          m_inten = 0;
    bit          m_int   = 0;
    logic [15:0] m_div   = 16'd434;
    int          m_pos   = 0;
    int          m_rem   = 0;
    bit          m_bits[10];
    bit          do_pop;
    bit          int_n;
    int          de;
    logic [7:0]  b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_busy = 0; m_ovf = 0; m_txen = 0; m_inten = 0; m_int = 0;
            m_div = 16'd434; m_pos = 0; m_rem = 0;
        end else begin
            de     = (m_div == 16'd0) ? 1 : int'(m_div);
            int_n  = m_inten && (q.size() == 0) && !m_busy;
            do_pop = !m_busy && m_txen && (q.size() != 0);
            if (m_busy) begin
                if (m_rem == 1) begin
                    m_pos++;
                    if (m_pos == 10) m_busy = 0;
                    else m_rem = de;
                end else begin
                    m_rem--;
                end
            end
            if (do_pop) begin
                b = q.pop_front();
                m_bits[0] = 0;
                for (int i = 0; i < 8; i++) m_bits[i+1] = b[i];
                m_bits[9] = 1;
                m_pos = 0; m_rem = de; m_busy = 1;
            end
            if (ce && we) begin
                case (addr[3:2])
                    2'd0: if (sel[0]) begin
                        if (q.size() < DEPTH) q.push_back(data[7:0]);
                        else m_ovf = 1;
                    end
                    2'd1: if (sel[0] && data[3]) m_ovf = 0;
                    2'd2: if (sel[0]) begin m_txen = data[0]; m_inten = data[1]; end
                    default: begin
                        if (sel[0]) m_div[7:0]  = data[7:0];
                        if (sel[1]) m_div[15:8] = data[15:8];
                    end
                endcase
            end
            m_int = int_n;
        end
    end

    function automatic logic [31:0] exp_read(input logic [1:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            2'd1: r = (32'(q.size()) << 4) | (32'(m_ovf) << 3) | (32'(q.size() == 0) << 2)
                      | (32'(q.size() == DEPTH) << 1) | 32'(m_busy);
            2'd2: r = {30'd0, m_inten, m_txen};
            2'd3: r = {16'd0, m_div};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("tx", {31'd0, tx}, {31'd0, (m_busy ? logic'(m_bits[m_pos]) : 1'b1)});
            chk("int_o", {31'd0, int_o}, {31'd0, m_int});
            chk("data_o", data_o, (ce && !we) ? exp_read(addr[3:2]) : 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        ce = 1; we = 1; addr = ($urandom & 32'hFFFF_FFF3) | {28'd0, a, 2'b00}; data = d; sel = s;
        @(posedge clk); #1;
        ce = 0; we = 0; sel = 4'd0; data = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, input string nm, input logic [31:0] exp);
        ce = 1; we = 0; addr = ($urandom & 32'hFFFF_FFF3) | {28'd0, a, 2'b00};
        @(negedge clk);
        chk(nm, data_o, exp);
        @(posedge clk); #1;
        ce = 0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((m_busy || q.size() != 0) && n < limit) begin tick(1); n++; end
        chk("drain_timeout", {31'd0, (n >= limit)}, 32'd0);
        bus_read(2'd1, "drain_status", 32'h4 | (32'(m_ovf) << 3));
    endtask

    function automatic logic exp_div_change(input int k);
        if (k <= 19) return 1'b1;
        if (k <= 27) return 1'b0;
        if (k <= 35) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        logic [9:0] fa5;
        int         r;
        int         n;
        logic [1:0] a;
        fa5 = 10'b1_1010_0101_0;

        #2 rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Reset state
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_int", {31'd0, int_o}, 32'd0);
        bus_read(2'd1, "reset_status", 32'h4);
        bus_read(2'd3, "reset_div", 32'd434);
        bus_read(2'd2, "reset_ctrl", 32'd0);
        bus_read(2'd0, "txdata_read", 32'd0);

        // Single byte 0xA5 at divisor 4
        bus_write(2'd3, 32'd4, 4'b0011);
        bus_write(2'd2, 32'd1, 4'b0001);
        bus_write(2'd0, 32'hA5, 4'b0001);
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("a5_frame", {31'd0, tx}, {31'd0, fa5[k/4]});
        end
        @(posedge clk); #1;
        bus_read(2'd1, "a5_busy_clear", 32'h4);

        // Divisor 4 -> 8 written during data bit 3 of 0x28
        bus_write(2'd0, 32'h28, 4'b0001);
        tick(17);
        bus_write(2'd3, 32'd8, 4'b0011);
        for (int k = 17; k <= 36; k++) begin
            @(negedge clk);
            chk("div_change", {31'd0, tx}, {31'd0, exp_div_change(k)});
        end
        @(posedge clk); #1;
        drain(500);

        // Reset in the middle of a frame
        bus_write(2'd0, 32'h55, 4'b0001);
        tick(10);
        rst = 1;
        #1;
        chk("tx_in_reset", {31'd0, tx}, 32'd1);
        chk("int_in_reset", {31'd0, int_o}, 32'd0);
        tick(2);
        rst = 0;
        bus_read(2'd1, "midreset_status", 32'h4);
        bus_read(2'd3, "midreset_div", 32'd434);
        bus_read(2'd2, "midreset_ctrl", 32'd0);

        // Overflow with transmitter disabled
        bus_write(2'd3, 32'd2, 4'b0011);
        for (int i = 0; i < 17; i++) bus_write(2'd0, $urandom, 4'b0001);
        bus_read(2'd1, "overflow_status", 32'h10A);
        bus_write(2'd1, 32'h8, 4'b0001);
        bus_read(2'd1, "overflow_cleared", 32'h102);

        // Full FIFO: push on the same edge as the first pop
        bus_write(2'd2, 32'd1, 4'b0001);
        bus_write(2'd0, 32'h3C, 4'b0001);
        bus_read(2'd1, "full_pop_push", 32'h103);
        drain(2000);

        // Interrupt
        bus_write(2'd2, 32'd3, 4'b0001);
        tick(1);
        chk("int_idle", {31'd0, int_o}, 32'd1);
        bus_write(2'd0, 32'h11, 4'b0001);
        bus_write(2'd0, 32'h22, 4'b0001);
        chk("int_busy", {31'd0, int_o}, 32'd0);
        n = 0;
        while (int_o !== 1'b1 && n < 200) begin tick(1); n++; end
        chk("int_rise_cycles", n, 32'd42);
        bus_write(2'd0, 32'h33, 4'b0001);
        chk("int_at_push", {31'd0, int_o}, 32'd1);
        tick(1);
        chk("int_after_push", {31'd0, int_o}, 32'd0);
        drain(500);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: bus_write(2'd0, $urandom, 4'($urandom_range(0, 15)) | ((r != 3) ? 4'd1 : 4'd0));
                4: bus_write(2'd2, 32'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
                5: bus_write(2'd3, 32'($urandom_range(0, 3)), 4'b0011);
                6: bus_write(2'd1, 32'h8, 4'b0001);
                7: begin
                    a = 2'($urandom_range(0, 3));
                    bus_read(a, "rand_read", exp_read(a));
                end
                default: tick($urandom_range(1, 20));
            endcase
        end
        bus_write(2'd3, 32'd1, 4'b0011);
        bus_write(2'd2, 32'd1, 4'b0001);
        drain(3000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
